// File: rtl/psum_drain_pkg.sv
// Shared definitions for the psum drain: FSM state encoding, default
// geometry and helper functions that derive the drain sizes.
package psum_drain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_ROW               = 16;
  localparam int DEF_COL               = 16;
  localparam int DEF_OUT_BITWIDTH      = 16;
  localparam int DEF_GBF_DATA_BITWIDTH = 512;
  localparam int DEF_GBF_ADDR_BITWIDTH = 8;

  // Total width of the flattened psum bus.
  function automatic int calc_psum_w(input int row, input int col, input int out_bw);
    return row * col * out_bw;
  endfunction

  // Number of GBF words needed to drain one snapshot.
  function automatic int calc_num_beats(input int psum_w, input int gbf_bw);
    return psum_w / gbf_bw;
  endfunction

  // Beat-counter width; never narrower than one bit.
  function automatic int calc_beat_w(input int num_beats);
    return (num_beats > 1) ? $clog2(num_beats) : 1;
  endfunction

endpackage

// File: rtl/psum_relu_lane.sv
// Single-element ReLU: negative two's-complement values become zero,
// non-negative values pass through unchanged. Purely combinational.
module psum_relu_lane #(
  parameter int W = 16
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = din[W-1] ? '0 : din;

endmodule

// File: rtl/psum_drain.sv
// Captures one snapshot of the PE array psum bus and writes it to the
// global buffer as GBF_DATA_BITWIDTH-wide words over a valid/ready port.
// Build option: define PSUM_DRAIN_RELU_EN to apply ReLU to every element
// as it is captured; otherwise the raw psum is captured bit-exact.
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int ROW               = DEF_ROW,
  parameter int COL               = DEF_COL,
  parameter int OUT_BITWIDTH      = DEF_OUT_BITWIDTH,
  parameter int GBF_DATA_BITWIDTH = DEF_GBF_DATA_BITWIDTH,
  parameter int GBF_ADDR_BITWIDTH = DEF_GBF_ADDR_BITWIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [GBF_ADDR_BITWIDTH-1:0]     base_addr,
  input  logic [OUT_BITWIDTH*ROW*COL-1:0]  psum_in,
  output logic                             gbf_w_valid,
  input  logic                             gbf_w_ready,
  output logic [GBF_ADDR_BITWIDTH-1:0]     gbf_w_addr,
  output logic [GBF_DATA_BITWIDTH-1:0]     gbf_w_data,
  output logic                             busy,
  output logic                             done
);

  localparam int PSUM_W    = calc_psum_w(ROW, COL, OUT_BITWIDTH);
  localparam int NUM_BEATS = calc_num_beats(PSUM_W, GBF_DATA_BITWIDTH);
  localparam int BEAT_W    = calc_beat_w(NUM_BEATS);
  localparam int NUM_ELEM  = ROW * COL;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  state_t                    state;
  state_t                    state_next;
  logic [BEAT_W-1:0]         beat;
  logic [PSUM_W-1:0]         snapshot;
  logic [PSUM_W-1:0]         captured;
  logic                      transfer;

  assign transfer = gbf_w_valid && gbf_w_ready;

`ifdef PSUM_DRAIN_RELU_EN
  for (genvar e = 0; e < NUM_ELEM; e++) begin : g_relu
    psum_relu_lane #(.W(OUT_BITWIDTH)) u_lane (
      .din  (psum_in [e*OUT_BITWIDTH +: OUT_BITWIDTH]),
      .dout (captured[e*OUT_BITWIDTH +: OUT_BITWIDTH])
    );
  end
`else
  assign captured = psum_in;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode: start only honoured in IDLE, last accepted beat ends SEND.
  always_comb begin
    // NOTE: default first so no branch leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SEND;
      SEND:    if (transfer && (beat == LAST_BEAT)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs; the snapshot shifts up one word per
  // accepted beat so the outgoing word is always its top slice.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the wide snapshot is reset only so gbf_w_data reads 0 after reset.
      snapshot    <= '0;
      beat        <= '0;
      gbf_w_addr  <= '0;
      gbf_w_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      gbf_w_valid <= (state_next == SEND);
      busy        <= (state_next != IDLE);
      done        <= (state_next == DONE);
      if ((state == IDLE) && start) begin
        snapshot   <= captured;
        gbf_w_addr <= base_addr;
        beat       <= '0;
      end else if (transfer) begin
        snapshot   <= snapshot << GBF_DATA_BITWIDTH;
        gbf_w_addr <= gbf_w_addr + GBF_ADDR_BITWIDTH'(1);
        if (beat != LAST_BEAT) beat <= beat + BEAT_W'(1);
      end
    end
  end

  assign gbf_w_data = snapshot[PSUM_W-1 -: GBF_DATA_BITWIDTH];

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain at default geometry. Each test drives
// a per-cycle plan (start pulses, ready stalls, reset, psum changes) and
// compares the observed GBF writes against an element-level model.
module tb_psum_drain;

  localparam int OB     = 16;
  localparam int NELEM  = 256;
  localparam int PSUM_W = OB * NELEM;
  localparam int GBF_W  = 512;
  localparam int EPW    = GBF_W / OB;
  localparam int NB     = PSUM_W / GBF_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        base_addr;
  logic [PSUM_W-1:0] psum_in;
  logic              gbf_w_valid;
  logic              gbf_w_ready;
  logic [7:0]        gbf_w_addr;
  logic [GBF_W-1:0]  gbf_w_data;
  logic              busy;
  logic              done;

  int compared   = 0;
  int mismatched = 0;

  bit                stall    [64];
  bit                start_at [64];
  int                reset_at;
  int                chg_at;
  logic [PSUM_W-1:0] chg_val;

  logic              obs_valid [64];
  logic              obs_busy  [64];
  logic [7:0]        obs_addr  [64];
  logic [GBF_W-1:0]  obs_data  [64];
  logic [7:0]        tr_addr   [$];
  logic [GBF_W-1:0]  tr_data   [$];
  int                tr_cycle  [$];
  int                done_cyc  [$];

  always #5 clk = ~clk;

  psum_drain dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .psum_in     (psum_in),
    .gbf_w_valid (gbf_w_valid),
    .gbf_w_ready (gbf_w_ready),
    .gbf_w_addr  (gbf_w_addr),
    .gbf_w_data  (gbf_w_data),
    .busy        (busy),
    .done        (done)
  );

  // Reference: word k lists elements from the PE(0,0) end downward,
  // first element in the word's MSBs, each optionally passed through ReLU.
  function automatic logic [GBF_W-1:0] exp_word(input logic [PSUM_W-1:0] ps, input int k);
    logic [GBF_W-1:0] w;
    logic [OB-1:0]    el;
    w = '0;
    for (int m = 0; m < EPW; m++) begin
      el = ps[(NELEM - 1 - k*EPW - m)*OB +: OB];
`ifdef PSUM_DRAIN_RELU_EN
      if ($signed(el) < 0) el = '0;
`endif
      w = (w << OB) | GBF_W'(el);
    end
    return w;
  endfunction

  function automatic logic [PSUM_W-1:0] rand_psum();
    logic [PSUM_W-1:0] p;
    for (int i = 0; i < PSUM_W/32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  task automatic clear_plan();
    foreach (stall[i])    stall[i] = 1'b0;
    foreach (start_at[i]) start_at[i] = 1'b0;
    reset_at = -1;
    chg_at   = -1;
    tr_addr.delete();
    tr_data.delete();
    tr_cycle.delete();
    done_cyc.delete();
  endtask

  // Cycle 0 raises start; cycles 1..ncyc-1 follow the plan. Outputs are
  // sampled on the falling edge; a transfer is logged when valid && ready.
  task automatic run_plan(input logic [7:0] base, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      start       = (c == 0) ? 1'b1 : start_at[c];
      base_addr   = base;
      gbf_w_ready = !stall[c];
      reset       = (c == reset_at);
      if (c == chg_at) psum_in = chg_val;
      @(negedge clk);
      obs_valid[c] = gbf_w_valid;
      obs_busy[c]  = busy;
      obs_addr[c]  = gbf_w_addr;
      obs_data[c]  = gbf_w_data;
      if (gbf_w_valid && gbf_w_ready && !reset) begin
        tr_addr.push_back(gbf_w_addr);
        tr_data.push_back(gbf_w_data);
        tr_cycle.push_back(c);
      end
      if (done) done_cyc.push_back(c);
    end
    @(posedge clk);
    #1;
    start       = 1'b0;
    reset       = 1'b0;
    gbf_w_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; gbf_w_ready = 1'b1; base_addr = '0; psum_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared += 5;
    if (gbf_w_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", gbf_w_valid); end
    if (gbf_w_addr !== 8'h00) begin mismatched++; $display("FAIL reset_addr: got %h want 00", gbf_w_addr); end
    if (gbf_w_data !== '0)    begin mismatched++; $display("FAIL reset_data: got %h want 0", gbf_w_data); end
    if (busy !== 1'b0)        begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0)        begin mismatched++; $display("FAIL reset_done: got %b want 0", done); end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [PSUM_W-1:0] snap;
    clear_plan();
    for (int e = 0; e < NELEM; e++) psum_in[e*OB +: OB] = OB'(e + 1);
    snap = psum_in;
    run_plan(8'h10, 12);
    compared++;
    if (tr_addr.size() != NB) begin mismatched++; $display("FAIL basic_count: got %0d want %0d", tr_addr.size(), NB); end
    for (int k = 0; k < NB && k < tr_addr.size(); k++) begin
      compared += 3;
      if (tr_addr[k] !== 8'(8'h10 + k)) begin mismatched++; $display("FAIL basic_addr k=%0d: got %h want %h", k, tr_addr[k], 8'(8'h10 + k)); end
      if (tr_data[k] !== exp_word(snap, k)) begin mismatched++; $display("FAIL basic_data k=%0d: got %h want %h", k, tr_data[k], exp_word(snap, k)); end
      if (tr_cycle[k] != 1 + k) begin mismatched++; $display("FAIL basic_cycle k=%0d: got %0d want %0d", k, tr_cycle[k], 1 + k); end
    end
    if (tr_addr.size() == NB) begin
      compared += 2;
      if (tr_data[0][GBF_W-1 -: OB] !== 16'd256) begin mismatched++; $display("FAIL basic_top_elem: got %0d want 256", tr_data[0][GBF_W-1 -: OB]); end
      if (tr_data[NB-1][OB-1:0] !== 16'd1) begin mismatched++; $display("FAIL basic_bottom_elem: got %0d want 1", tr_data[NB-1][OB-1:0]); end
    end
    compared++;
    if (done_cyc.size() != 1 || done_cyc[0] != 9) begin
      mismatched++; $display("FAIL basic_done: got %0d pulses first at %0d want 1 at 9", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
    for (int c = 0; c < 12; c++) begin
      compared++;
      if (obs_busy[c] !== (c >= 1 && c <= 9)) begin mismatched++; $display("FAIL basic_busy c=%0d: got %b want %b", c, obs_busy[c], (c >= 1 && c <= 9)); end
    end
  endtask

  task automatic test_backpressure();
    logic [PSUM_W-1:0] snap;
    clear_plan();
    snap = psum_in;
    for (int c = 2; c <= 4; c++) stall[c] = 1'b1;
    run_plan(8'h10, 15);
    for (int c = 2; c <= 4; c++) begin
      compared += 3;
      if (obs_valid[c] !== 1'b1) begin mismatched++; $display("FAIL bp_valid c=%0d: got %b want 1", c, obs_valid[c]); end
      if (obs_addr[c] !== 8'h11) begin mismatched++; $display("FAIL bp_addr c=%0d: got %h want 11", c, obs_addr[c]); end
      if (obs_data[c] !== exp_word(snap, 1)) begin mismatched++; $display("FAIL bp_data c=%0d: got %h want %h", c, obs_data[c], exp_word(snap, 1)); end
    end
    compared++;
    if (tr_addr.size() != NB) begin mismatched++; $display("FAIL bp_count: got %0d want %0d", tr_addr.size(), NB); end
    for (int k = 0; k < NB && k < tr_addr.size(); k++) begin
      compared++;
      if (tr_data[k] !== exp_word(snap, k)) begin mismatched++; $display("FAIL bp_seq_data k=%0d: got %h want %h", k, tr_data[k], exp_word(snap, k)); end
    end
    compared++;
    if (done_cyc.size() != 1 || done_cyc[0] != 12) begin
      mismatched++; $display("FAIL bp_done: got %0d pulses first at %0d want 1 at 12", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
  endtask

  task automatic test_isolation_wrap();
    logic [PSUM_W-1:0] snap;
    clear_plan();
    psum_in = rand_psum();
    snap    = psum_in;
    chg_at  = 1;
    chg_val = '1;
    run_plan(8'hFC, 12);
    compared++;
    if (tr_addr.size() != NB) begin mismatched++; $display("FAIL iso_count: got %0d want %0d", tr_addr.size(), NB); end
    for (int k = 0; k < NB && k < tr_addr.size(); k++) begin
      compared += 2;
      if (tr_addr[k] !== 8'(8'hFC + k)) begin mismatched++; $display("FAIL wrap_addr k=%0d: got %h want %h", k, tr_addr[k], 8'(8'hFC + k)); end
      if (tr_data[k] !== exp_word(snap, k)) begin mismatched++; $display("FAIL iso_data k=%0d: got %h want %h", k, tr_data[k], exp_word(snap, k)); end
    end
  endtask

  task automatic test_start_ignored();
    logic [PSUM_W-1:0] snap;
    clear_plan();
    snap = psum_in;
    start_at[3]  = 1'b1;
    start_at[9]  = 1'b1;
    start_at[10] = 1'b1;
    run_plan(8'h40, 22);
    compared += 2;
    if (done_cyc.size() != 2 || done_cyc[0] != 9 || done_cyc[1] != 19) begin
      mismatched++; $display("FAIL restart_done: got %0d pulses want 2 at 9 and 19", done_cyc.size());
    end
    if (obs_valid[10] !== 1'b0) begin mismatched++; $display("FAIL restart_gap_valid: got %b want 0", obs_valid[10]); end
    compared++;
    if (tr_addr.size() != 2*NB) begin mismatched++; $display("FAIL restart_count: got %0d want %0d", tr_addr.size(), 2*NB); end
    for (int k = 0; k < 2*NB && k < tr_addr.size(); k++) begin
      compared += 3;
      if (tr_cycle[k] != ((k < NB) ? 1 + k : 3 + k)) begin mismatched++; $display("FAIL restart_cycle k=%0d: got %0d want %0d", k, tr_cycle[k], (k < NB) ? 1 + k : 3 + k); end
      if (tr_addr[k] !== 8'(8'h40 + k % NB)) begin mismatched++; $display("FAIL restart_addr k=%0d: got %h want %h", k, tr_addr[k], 8'(8'h40 + k % NB)); end
      if (tr_data[k] !== exp_word(snap, k % NB)) begin mismatched++; $display("FAIL restart_data k=%0d: got %h want %h", k, tr_data[k], exp_word(snap, k % NB)); end
    end
  endtask

  task automatic test_reset_mid();
    clear_plan();
    reset_at = 4;
    run_plan(8'h20, 14);
    compared += 5;
    if (obs_valid[4] !== 1'b1) begin mismatched++; $display("FAIL rstmid_pre_valid: got %b want 1", obs_valid[4]); end
    if (obs_valid[5] !== 1'b0) begin mismatched++; $display("FAIL rstmid_valid: got %b want 0", obs_valid[5]); end
    if (obs_busy[5] !== 1'b0)  begin mismatched++; $display("FAIL rstmid_busy: got %b want 0", obs_busy[5]); end
    if (done_cyc.size() != 0)  begin mismatched++; $display("FAIL rstmid_done: got %0d pulses want 0", done_cyc.size()); end
    if (tr_addr.size() != 3)   begin mismatched++; $display("FAIL rstmid_count: got %0d want 3", tr_addr.size()); end
  endtask

  task automatic test_relu();
    logic [PSUM_W-1:0] snap;
    logic [OB-1:0]     want_low;
    clear_plan();
    psum_in = rand_psum();
    psum_in[0 +: OB]              = 16'h8001;
    psum_in[(NELEM-1)*OB +: OB]   = 16'h7FFF;
    snap = psum_in;
`ifdef PSUM_DRAIN_RELU_EN
    want_low = 16'h0000;
`else
    want_low = 16'h8001;
`endif
    run_plan(8'h80, 12);
    compared++;
    if (tr_addr.size() != NB) begin mismatched++; $display("FAIL relu_count: got %0d want %0d", tr_addr.size(), NB); end
    if (tr_addr.size() == NB) begin
      compared += 2;
      if (tr_data[0][GBF_W-1 -: OB] !== 16'h7FFF) begin mismatched++; $display("FAIL relu_pos: got %h want 7fff", tr_data[0][GBF_W-1 -: OB]); end
      if (tr_data[NB-1][OB-1:0] !== want_low) begin mismatched++; $display("FAIL relu_neg: got %h want %h", tr_data[NB-1][OB-1:0], want_low); end
      for (int k = 0; k < NB; k++) begin
        compared++;
        if (tr_data[k] !== exp_word(snap, k)) begin mismatched++; $display("FAIL relu_data k=%0d: got %h want %h", k, tr_data[k], exp_word(snap, k)); end
      end
    end
  endtask

  task automatic test_random();
    logic [PSUM_W-1:0] snap;
    logic [7:0]        base;
    for (int it = 0; it < 4; it++) begin
      clear_plan();
      psum_in = rand_psum();
      snap    = psum_in;
      base    = 8'($urandom);
      for (int c = 1; c < 30; c++) stall[c] = ($urandom_range(0, 9) < 3);
      run_plan(base, 40);
      compared++;
      if (tr_addr.size() != NB) begin mismatched++; $display("FAIL rand%0d_count: got %0d want %0d", it, tr_addr.size(), NB); end
      for (int k = 0; k < NB && k < tr_addr.size(); k++) begin
        compared += 2;
        if (tr_addr[k] !== 8'(base + k)) begin mismatched++; $display("FAIL rand%0d_addr k=%0d: got %h want %h", it, k, tr_addr[k], 8'(base + k)); end
        if (tr_data[k] !== exp_word(snap, k)) begin mismatched++; $display("FAIL rand%0d_data k=%0d: got %h want %h", it, k, tr_data[k], exp_word(snap, k)); end
      end
      compared++;
      if (done_cyc.size() != 1 || tr_cycle.size() != NB || done_cyc[0] != tr_cycle[NB-1] + 1) begin
        mismatched++; $display("FAIL rand%0d_done: got %0d pulses first at %0d", it, done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_isolation_wrap();
    test_start_ignored();
    test_reset_mid();
    test_relu();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
